// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter
// Packet-granular round-robin arbiter sharing one Aurora TX AXI-Stream link
// between SRC_NUM packet framers (ADC framer plus status/command framers).
// A granted source owns the link until its tlast beat is accepted, so packets
// never interleave. Arbitration takes one idle cycle per packet boundary.
//
// Build option:
//   AURORA_ARB_PRIO0_EN - when defined, source 0 wins every arbitration it
//                         requests; round-robin runs only over sources 1..N-1.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_rst         synchronous soft clear (state, counters, sop_err)
//   s_axis_*        SRC_NUM packed source streams, source i at slice i
//   m_axis_*        merged stream to the Aurora user TX interface
//   grant           one-hot current owner, zero when idle
//   busy            a packet is in flight
//   pkt_cnt         per-source count of accepted tlast beats, wraps
//   sop_err         sticky: a packet's first beat was accepted with tuser=0
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no owner; pick next requester, no beat moves this cycle
// ST_PKT  | owner streams straight through until its tlast is accepted

module aurora_tx_arbiter #(
   parameter int DATA_WD = 128,
   parameter int SRC_NUM = 2,
   parameter int CNT_WD  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_rst,
   input  logic [SRC_NUM*DATA_WD-1:0]    s_axis_tdata,
   input  logic [SRC_NUM*DATA_WD/8-1:0]  s_axis_tkeep,
   input  logic [SRC_NUM-1:0]            s_axis_tvalid,
   output logic [SRC_NUM-1:0]            s_axis_tready,
   input  logic [SRC_NUM-1:0]            s_axis_tlast,
   input  logic [SRC_NUM-1:0]            s_axis_tuser,
   output logic [DATA_WD-1:0]            m_axis_tdata,
   output logic [DATA_WD/8-1:0]          m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic [SRC_NUM-1:0]            grant,
   output logic                          busy,
   output logic [SRC_NUM*CNT_WD-1:0]     pkt_cnt,
   output logic                          sop_err
);

   localparam int KEEP_WD = DATA_WD / 8;
   localparam int IDX_WD  = $clog2(SRC_NUM);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } state_t;

   state_t                     state;
   logic [IDX_WD-1:0]          gidx;
   logic [IDX_WD-1:0]          ptr;
   logic [SRC_NUM-1:0]         grant_q;
   logic                       first_beat;
   logic [SRC_NUM*CNT_WD-1:0]  cnt_q;
   logic                       sop_err_q;

   logic [IDX_WD-1:0]          sel_idx;
   logic                       sel_hit;
   int                         cand;
   logic                       beat_acc;

   // Walk downward so the candidate nearest ptr+1 is written last and wins.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      cand    = 0;
`ifdef AURORA_ARB_PRIO0_EN
      for (int k = SRC_NUM; k >= 1; k--) begin
         cand = (int'(ptr) + k) % SRC_NUM;
         if (cand != 0 && s_axis_tvalid[cand]) begin
            sel_hit = 1'b1;
            sel_idx = IDX_WD'(cand);
         end
      end
      if (s_axis_tvalid[0]) begin
         sel_hit = 1'b1;
         sel_idx = '0;
      end
`else
      for (int k = SRC_NUM; k >= 1; k--) begin
         cand = (int'(ptr) + k) % SRC_NUM;
         if (s_axis_tvalid[cand]) begin
            sel_hit = 1'b1;
            sel_idx = IDX_WD'(cand);
         end
      end
`endif
   end

   // Zero-latency pass-through of the owner; everything else held at zero.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
      if (state == ST_PKT) begin
         m_axis_tdata        = s_axis_tdata[int'(gidx)*DATA_WD +: DATA_WD];
         m_axis_tkeep        = s_axis_tkeep[int'(gidx)*KEEP_WD +: KEEP_WD];
         m_axis_tvalid       = s_axis_tvalid[gidx];
         m_axis_tlast        = s_axis_tlast[gidx];
         m_axis_tuser        = s_axis_tuser[gidx];
         s_axis_tready[gidx] = m_axis_tready;
      end
   end

   assign beat_acc = (state == ST_PKT) && m_axis_tvalid && m_axis_tready;

   always_ff @(posedge clk) begin
      if (rst || cfg_rst) begin
         state      <= ST_IDLE;
         grant_q    <= '0;
         gidx       <= '0;
         ptr        <= IDX_WD'(SRC_NUM - 1);
         first_beat <= 1'b0;
         cnt_q      <= '0;
         sop_err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sel_hit) begin
                  state      <= ST_PKT;
                  gidx       <= sel_idx;
                  grant_q    <= {{(SRC_NUM-1){1'b0}}, 1'b1} << sel_idx;
                  first_beat <= 1'b1;
`ifdef AURORA_ARB_PRIO0_EN
                  // Priority grants to source 0 leave the rotation untouched.
                  if (sel_idx != '0) ptr <= sel_idx;
`else
                  ptr <= sel_idx;
`endif
               end
            end
            ST_PKT: begin
               if (beat_acc) begin
                  first_beat <= 1'b0;
                  if (first_beat && !m_axis_tuser) sop_err_q <= 1'b1;
                  if (m_axis_tlast) begin
                     cnt_q[int'(gidx)*CNT_WD +: CNT_WD] <=
                        cnt_q[int'(gidx)*CNT_WD +: CNT_WD] + CNT_WD'(1);
                     state   <= ST_IDLE;
                     grant_q <= '0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign grant   = grant_q;
   assign busy    = (state == ST_PKT);
   assign pkt_cnt = cnt_q;
   assign sop_err = sop_err_q;

endmodule
